// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter_pkg
//  Description : Shared types and constants for the frequency meter:
//                sequencer state encoding, gate range encoding, gate-length
//                divisors, BCD count width and a gate-length helper.
//  Revision    : 1.0  initial release
// ============================================================================
package freq_meter_pkg;

    // Width of the 4-digit BCD count word.
    localparam int BCD_W = 16;

    // Measurement sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_GATE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LATCH  = 3'd4
    } state_t;

    // Gate range select encoding; the unused code 3 selects the 1 s gate.
    localparam logic [1:0] RANGE_1S    = 2'd0;
    localparam logic [1:0] RANGE_100MS = 2'd1;
    localparam logic [1:0] RANGE_10MS  = 2'd2;

    // System-clock divisors giving the gate length for each range.
    localparam int unsigned DIV_1S    = 1;
    localparam int unsigned DIV_100MS = 10;
    localparam int unsigned DIV_10MS  = 100;

    // Gate length in system clock cycles for a given range select.
    function automatic logic [31:0] gate_len(input logic [1:0] rs,
                                             input int unsigned clk_hz);
        logic [31:0] len;
        len = clk_hz / DIV_1S;
        case (rs)
            RANGE_100MS: len = clk_hz / DIV_100MS;
            RANGE_10MS:  len = clk_hz / DIV_10MS;
            default:     len = clk_hz / DIV_1S;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : freq_gate_ctrl_if
//  Description : Signal bundle between the measurement sequencer and its
//                surroundings (run control, BCD counter, display result).
//                master : the sequencer (drives counter control and result)
//                slave  : the environment (drives run, range and count)
//  Revision    : 1.0  initial release
// ============================================================================
interface freq_gate_ctrl_if;
    import freq_meter_pkg::*;

    logic             run;
    logic [1:0]       range_sel;
    logic [BCD_W-1:0] cnt_in;
    logic             cnt_clean;
    logic             cnt_en;
    logic [BCD_W-1:0] result;
    logic [1:0]       result_range;
    logic             result_valid;
    logic             overflow;
    logic             busy;

    modport master (
        input  run, range_sel, cnt_in,
        output cnt_clean, cnt_en, result, result_range, result_valid,
               overflow, busy
    );

    modport slave (
        output run, range_sel, cnt_in,
        input  cnt_clean, cnt_en, result, result_range, result_valid,
               overflow, busy
    );

endinterface
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
//  Module      : bit_sync
//  Description : Two-flop synchronizer for a single asynchronous bit,
//                both stages reset to 0.
//  Ports       : clk, rst (sync, active high), d (async in), q (synced out)
//  Revision    : 1.0  initial release
// ============================================================================
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            q      <= 1'b0;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/freq_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : freq_gate_ctrl
//  Description : Frequency meter measurement sequencer. Clears the external
//                BCD counter, opens a gate of 1 s / 100 ms / 10 ms of system
//                clock, waits for the counter to settle, then latches the
//                count, range and wrap (overflow) status for display.
//  Ports       : clk, rst (sync, active high)
//                bus (freq_gate_ctrl_if.master): run, range_sel, cnt_in in;
//                cnt_clean, cnt_en, result, result_range, result_valid,
//                overflow, busy out
//  Revision    : 1.0  initial release
// ============================================================================
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned CLR_CYC    = 4,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    freq_gate_ctrl_if.master bus
);

    // The shortest gate must be at least one cycle, and the clear/settle
    // phases must exist, otherwise the down-counters would start at zero.
    if ((CLK_HZ / DIV_10MS) < 1 || CLR_CYC < 1 || SETTLE_CYC < 1) begin : g_param_check
        $error("freq_gate_ctrl: CLK_HZ/100, CLR_CYC and SETTLE_CYC must all be >= 1");
    end

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_phase;       // remaining cycles of CLEAR or SETTLE
    logic [31:0] r_gate;        // remaining gate cycles
    logic [1:0]  r_range_q;
    logic        r_ovf_flag;
    logic        r_sync_d;
    logic        w_sync;
    logic        w_wrap;
    logic        w_enter_clear;

    bit_sync u_msb_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.cnt_in[BCD_W-1]),
        .q   (w_sync)
    );

    // Top BCD bit falling means the most significant digit went 9 -> 0.
    assign w_wrap        = r_sync_d & ~w_sync;
    assign w_enter_clear = (w_next == ST_CLEAR) && (r_state != ST_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (bus.run)              w_next = ST_CLEAR;
            ST_CLEAR:  if (r_phase == 32'd1)     w_next = ST_GATE;
            ST_GATE:   if (r_gate == 32'd1)      w_next = ST_SETTLE;
            ST_SETTLE: if (r_phase == 32'd1)     w_next = ST_LATCH;
            ST_LATCH:  w_next = bus.run ? ST_CLEAR : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that each output changes
    // on the same edge as the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase          <= '0;
            r_gate           <= '0;
            r_range_q        <= '0;
            r_ovf_flag       <= 1'b0;
            r_sync_d         <= 1'b0;
            bus.cnt_clean    <= 1'b0;
            bus.cnt_en       <= 1'b0;
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result       <= '0;
            bus.result_range <= '0;
            bus.overflow     <= 1'b0;
        end else begin
            r_sync_d         <= w_sync;
            bus.cnt_clean    <= (w_next == ST_GATE) || (w_next == ST_SETTLE) ||
                                (w_next == ST_LATCH);
            bus.cnt_en       <= (w_next == ST_GATE);
            bus.busy         <= (w_next != ST_IDLE);
            bus.result_valid <= (w_next == ST_LATCH);

            if (w_next == ST_LATCH) begin
                bus.result       <= bus.cnt_in;
                bus.result_range <= r_range_q;
                bus.overflow     <= r_ovf_flag | w_wrap;
            end

            if (w_enter_clear) begin
                r_range_q  <= bus.range_sel;
                r_gate     <= gate_len(bus.range_sel, CLK_HZ);
                r_phase    <= CLR_CYC;
                r_ovf_flag <= 1'b0;
            end else begin
                case (r_state)
                    ST_CLEAR: begin
                        r_phase    <= r_phase - 32'd1;
                        r_ovf_flag <= 1'b0;
                    end
                    ST_GATE: begin
                        r_gate <= r_gate - 32'd1;
                        if (w_next == ST_SETTLE) r_phase <= SETTLE_CYC;
                        if (w_wrap)              r_ovf_flag <= 1'b1;
                    end
                    ST_SETTLE: begin
                        r_phase <= r_phase - 32'd1;
                        if (w_wrap) r_ovf_flag <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_gate_ctrl
//  Description : Self-checking bench for freq_gate_ctrl with a behavioural
//                BCD signal counter and a timeline model of the measurement.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_freq_gate_ctrl;

    localparam int CLK_HZ = 1000;
    localparam int CLR    = 4;
    localparam int SETTLE = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] cnt_q = '0;

    int checks   = 0;
    int failures = 0;

    // Signal counter stimulus: 'step' edges on every 'per'-th enabled cycle,
    // plus 'extra' edges on the first enabled cycle.
    int cfg_step  = 1;
    int cfg_per   = 1;
    int cfg_extra = 0;

    freq_gate_ctrl_if bus ();

    freq_gate_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .CLR_CYC    (CLR),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.cnt_in = cnt_q;

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        int x;
        logic [15:0] b;
        x = v % 10000;
        b[3:0]   = 4'(x % 10);
        b[7:4]   = 4'((x / 10) % 10);
        b[11:8]  = 4'((x / 100) % 10);
        b[15:12] = 4'((x / 1000) % 10);
        return b;
    endfunction

    function automatic int gate_cycles(input logic [1:0] rs);
        case (rs)
            2'd1:    return CLK_HZ / 10;
            2'd2:    return CLK_HZ / 100;
            default: return CLK_HZ;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural BCD counter -----------------------------
    int c_val = 0, c_idx = 0, c_step = 0, c_per = 1, c_extra = 0;
    always @(posedge clk) begin
        if (!bus.cnt_clean) begin
            c_val   = 0;
            c_idx   = 0;
            c_step  = cfg_step;
            c_per   = cfg_per;
            c_extra = cfg_extra;
        end else if (bus.cnt_en) begin
            if (c_idx % c_per == 0) c_val += c_step;
            if (c_idx == 0)         c_val += c_extra;
            c_idx++;
        end
        cnt_q <= to_bcd(c_val);
    end

    // ---------------- measurement timeline model --------------------------
    bit          m_active = 0;
    int          m_off = 0, m_G = 0, m_last = 0, total = 0;
    logic [1:0]  m_range = '0;
    logic [15:0] m_result = '0;
    logic [1:0]  m_rrange = '0;
    logic        m_ovf = 1'b0;
    int          s_step = 0, s_per = 1, s_extra = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0;
            m_off    = 0;
            m_result = '0;
            m_rrange = '0;
            m_ovf    = 1'b0;
        end else if (!m_active || m_off == m_last) begin
            if (bus.run) begin
                m_active = 1;
                m_off    = 0;
                m_range  = bus.range_sel;
                m_G      = gate_cycles(bus.range_sel);
                m_last   = CLR + m_G + SETTLE;
                s_step   = cfg_step;
                s_per    = cfg_per;
                s_extra  = cfg_extra;
            end else begin
                m_active = 0;
            end
        end else begin
            m_off++;
            if (m_off == m_last) begin
                total    = s_extra + s_step * ((m_G + s_per - 1) / s_per);
                m_result = to_bcd(total);
                m_ovf    = (total >= 10000);
                m_rrange = m_range;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic e_clean, e_en, e_busy, e_valid;
        e_busy  = m_active;
        e_clean = m_active && (m_off >= CLR);
        e_en    = m_active && (m_off >= CLR) && (m_off < CLR + m_G);
        e_valid = m_active && (m_off == m_last);
        check("outputs{clean,en,busy,valid,ovf,range,result}",
              32'({bus.cnt_clean, bus.cnt_en, bus.busy, bus.result_valid,
                   bus.overflow, bus.result_range, bus.result}),
              32'({e_clean, e_en, e_busy, e_valid, m_ovf, m_rrange, m_result}));
    end

    // ---------------- gate-length / period monitor ------------------------
    int cyc = 0, en_run = 0, last_en = 0, last_valid_cyc = 0;
    int last_period = 0, valid_count = 0;
    always @(negedge clk) begin
        cyc++;
        if (rst)             en_run = 0;
        else if (bus.cnt_en) en_run++;
        if (bus.result_valid) begin
            last_en        = en_run;
            en_run         = 0;
            last_period    = cyc - last_valid_cyc;
            last_valid_cyc = cyc;
            valid_count++;
        end
    end

    task automatic step_n(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        step_n(1);
        while (!bus.result_valid && n < budget) begin
            step_n(1);
            n++;
        end
        check({name, " result_valid seen"}, 32'(bus.result_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus with literal expectations ---------
    initial begin
        int vc;
        bus.run       = 1'b0;
        bus.range_sel = 2'd0;
        rst           = 1'b1;
        step_n(3);
        check("reset busy",      32'(bus.busy),         32'd0);
        check("reset cnt_clean", 32'(bus.cnt_clean),    32'd0);
        check("reset cnt_en",    32'(bus.cnt_en),       32'd0);
        check("reset result",    32'(bus.result),       32'h0000);
        check("reset valid",     32'(bus.result_valid), 32'd0);
        rst = 1'b0;
        step_n(2);
        check("idle busy", 32'(bus.busy), 32'd0);

        // 1 s gate, 250 edges
        cfg_step = 1; cfg_per = 4; cfg_extra = 0;
        bus.run = 1'b1;
        step_n(1);
        check("busy after run", 32'(bus.busy), 32'd1);
        check("clear cnt_clean", 32'(bus.cnt_clean), 32'd0);
        wait_valid("1s", 1100);
        check("1s result",   32'(bus.result),       32'h0250);
        check("1s overflow", 32'(bus.overflow),     32'd0);
        check("1s range",    32'(bus.result_range), 32'd0);
        check("1s gate len", 32'(last_en),          32'd1000);

        // 10 ms gate, period between pulses
        bus.range_sel = 2'd2;
        cfg_step = 1; cfg_per = 1; cfg_extra = 3;
        wait_valid("10ms a", 60);
        check("10ms result",   32'(bus.result),  32'h0013);
        check("10ms gate len", 32'(last_en),     32'd10);
        check("10ms period a", 32'(last_period), 32'd23);
        step_n(1);
        check("valid one cycle", 32'(bus.result_valid), 32'd0);
        check("result holds",    32'(bus.result),       32'h0013);
        wait_valid("10ms b", 60);
        check("10ms period b", 32'(last_period), 32'd23);

        // 100 ms gate with wrap past 9999
        bus.range_sel = 2'd1;
        cfg_step = 100; cfg_per = 1; cfg_extra = 12;
        wait_valid("wrap", 200);
        check("wrap result",   32'(bus.result),       32'h0012);
        check("wrap overflow", 32'(bus.overflow),     32'd1);
        check("wrap range",    32'(bus.result_range), 32'd1);
        check("wrap gate len", 32'(last_en),          32'd100);
        cfg_step = 1; cfg_per = 1; cfg_extra = 0;
        wait_valid("nowrap", 200);
        check("nowrap result",   32'(bus.result),   32'h0100);
        check("nowrap overflow", 32'(bus.overflow), 32'd0);

        // range change during GATE takes effect next measurement
        bus.range_sel = 2'd0;
        cfg_step = 1; cfg_per = 4; cfg_extra = 0;
        step_n(20);
        bus.range_sel = 2'd1;
        wait_valid("rchg a", 1100);
        check("rchg a range",    32'(bus.result_range), 32'd0);
        check("rchg a gate len", 32'(last_en),          32'd1000);
        wait_valid("rchg b", 200);
        check("rchg b range",    32'(bus.result_range), 32'd1);
        check("rchg b gate len", 32'(last_en),          32'd100);
        check("rchg b result",   32'(bus.result),       32'h0025);

        // run dropped mid-GATE: finish then IDLE
        bus.range_sel = 2'd2;
        step_n(8);
        bus.run = 1'b0;
        wait_valid("stop", 60);
        check("stop result", 32'(bus.result),       32'h0003);
        check("stop range",  32'(bus.result_range), 32'd2);
        step_n(1);
        check("stop busy",      32'(bus.busy),      32'd0);
        check("stop cnt_clean", 32'(bus.cnt_clean), 32'd0);
        vc = valid_count;
        step_n(40);
        check("stop no more valid", 32'(valid_count), 32'(vc));

        // reset mid-GATE, then restart with run still high
        bus.range_sel = 2'd0;
        bus.run = 1'b1;
        step_n(30);
        rst = 1'b1;
        step_n(1);
        check("rst cnt_en",    32'(bus.cnt_en),    32'd0);
        check("rst cnt_clean", 32'(bus.cnt_clean), 32'd0);
        check("rst result",    32'(bus.result),    32'h0000);
        check("rst busy",      32'(bus.busy),      32'd0);
        rst = 1'b0;
        step_n(1);
        check("restart busy",      32'(bus.busy),      32'd1);
        check("restart cnt_clean", 32'(bus.cnt_clean), 32'd0);
        wait_valid("restart", 1100);
        check("restart result",   32'(bus.result), 32'h0250);
        check("restart gate len", 32'(last_en),    32'd1000);

        bus.run = 1'b0;
        step_n(30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
